spi_slave: RTL

- SPI target (peripheral-side) endpoint. Pairs with spi_master over sclk/mosi/miso and adds chip select cs_n.
- Oversamples the external SPI pins with the system clock: synchronises, detects edges, shifts in mosi and drives miso.
- Uses the same spi_config_t fields as the master (spi_mode, spi_frame_size, bit_order). The prescaler field is ignored.
- Hands each received word to the core with a 1-cycle valid pulse.

---
 rtl/spi_slave.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI target endpoint that oversamples sclk/cs_n/mosi with the system clock.
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky receive-overrun flag driven by rx_ack.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_FRAME_SIZE_8  = 2'd0,
    SPI_FRAME_SIZE_16 = 2'd1,
    SPI_FRAME_SIZE_32 = 2'd2
  } spi_frame_size_t;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } spi_bit_order_t;

  typedef struct packed {
    logic [15:0]     prescaler;
    logic [1:0]      spi_mode;
    spi_frame_size_t spi_frame_size;
    spi_bit_order_t  bit_order;
  } spi_config_t;

endpackage

module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  spi_pkg::spi_config_t spi_config,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [31:0]         tx_data,
  output logic [31:0]         rx_data,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                rx_overrun,
  output logic                busy
);
  import spi_pkg::*;

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [5:0] frame_len(input spi_frame_size_t s);
    case (s)
      SPI_FRAME_SIZE_8:  return 6'd8;
      SPI_FRAME_SIZE_16: return 6'd16;
      default:           return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] frame_mask(input logic [5:0] n);
    return (n == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic head_bit(input logic [31:0] w, input logic [5:0] n,
                                    input spi_bit_order_t o);
    logic [4:0] top;
    top = 5'(n - 6'd1);
    return (o == LSB_FIRST) ? w[0] : w[top];
  endfunction

  function automatic logic [31:0] tx_advance(input logic [31:0] w, input spi_bit_order_t o);
    return (o == LSB_FIRST) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [31:0] rx_insert(input logic [31:0] w, input logic b,
                                            input logic [5:0] n, input spi_bit_order_t o);
    logic [31:0] r;
    logic [4:0]  top;
    top = 5'(n - 6'd1);
    if (o == LSB_FIRST) begin
      r      = w >> 1;
      r[top] = b;
    end else begin
      r = {w[30:0], b};
    end
    return r & frame_mask(n);
  endfunction

  // Input synchronisers; cs_n resets to "selected" so a cs_n still held low after
  // reset never looks like a fresh falling edge.
  logic [SYNC_N-1:0] sclk_sync, cs_sync, mosi_sync;
  logic              sclk_q, cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_N-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_N-2:0], cs_n};
      sclk_q    <= sclk_sync[SYNC_N-1];
      cs_q      <= cs_sync[SYNC_N-1];
    end
  end

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_N-2:0], mosi};
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync[SYNC_N-1];
  assign cs_s      = cs_sync[SYNC_N-1];
  assign mosi_s    = mosi_sync[SYNC_N-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  // Edge roles from the configuration latched at frame start
  state_t          state;
  logic [1:0]      cfg_mode;
  spi_frame_size_t cfg_size;
  spi_bit_order_t  cfg_order;
  logic [5:0]      n_bits, bit_cnt;
  logic [31:0]     tx_sh, rx_sh, tx_nxt, rx_nxt;
  logic            fresh;
  logic            lead_edge, trail_edge, sample_edge, shift_edge, last_bit, frame_done;

  assign n_bits      = frame_len(cfg_size);
  assign lead_edge   = cfg_mode[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = cfg_mode[1] ? sclk_rise : sclk_fall;
  assign sample_edge = cfg_mode[0] ? trail_edge : lead_edge;
  assign shift_edge  = cfg_mode[0] ? lead_edge : trail_edge;
  assign last_bit    = (bit_cnt == n_bits - 6'd1);
  assign frame_done  = (state == ACTIVE) && sample_edge && last_bit;
  assign rx_nxt      = rx_insert(rx_sh, mosi_s, n_bits, cfg_order);
  assign tx_nxt      = tx_advance(tx_sh, cfg_order);

  // fresh marks a freshly loaded tx word whose first bit has not yet been put on
  // miso by a shift edge; that edge presents the head bit instead of advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_mode  <= 2'd0;
      cfg_size  <= SPI_FRAME_SIZE_8;
      cfg_order <= MSB_FIRST;
      bit_cnt   <= 6'd0;
      fresh     <= 1'b0;
      rx_data   <= 32'd0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            cfg_mode  <= spi_config.spi_mode;
            cfg_size  <= spi_config.spi_frame_size;
            cfg_order <= spi_config.bit_order;
            tx_sh     <= tx_data;
            miso      <= head_bit(tx_data, frame_len(spi_config.spi_frame_size),
                                  spi_config.bit_order);
            fresh     <= spi_config.spi_mode[0];
            bit_cnt   <= 6'd0;
            busy      <= 1'b1;
            miso_oe   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sample_edge) begin
            rx_sh <= rx_nxt;
            if (last_bit) begin
              bit_cnt  <= 6'd0;
              rx_data  <= rx_nxt;
              rx_valid <= 1'b1;
              tx_sh    <= tx_data;
              fresh    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          if (shift_edge) begin
            if (fresh) begin
              miso  <= head_bit(tx_sh, n_bits, cfg_order);
              fresh <= 1'b0;
            end else begin
              tx_sh <= tx_nxt;
              miso  <= head_bit(tx_nxt, n_bits, cfg_order);
            end
          end
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= 6'd0;
            fresh   <= 1'b0;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (frame_done) begin
      pending <= 1'b1;
      if (pending && !rx_ack) rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      pending <= 1'b0;
    end
  end
`else
  logic unused_ack;
  logic unused_done;
  assign unused_ack  = rx_ack;
  assign unused_done = frame_done;
  assign rx_overrun  = 1'b0;
`endif

  logic unused_cfg;
  assign unused_cfg = ^spi_config.prescaler;

endmodule
